// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder/subtractor, one full-adder cell sequenced LSB first over WIDTH cycles
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_b,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    input  logic             i_sub,
    output logic             o_busy,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_sum;
    logic [CW-1:0]    r_cnt;
    logic             r_c, r_cout, r_ovf;
    logic             w_s, w_co, w_last, w_accept;

    assign w_s      = r_a[0] ^ r_b[0] ^ r_c;
    assign w_co     = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);
    assign w_last   = r_cnt == CW'(WIDTH - 1);
    assign w_accept = i_in_valid && r_state == IDLE;

    assign o_in_ready  = r_state == IDLE;
    assign o_busy      = r_state == RUN;
    assign o_out_valid = r_state == HOLD;
    assign o_sum       = r_sum;
    assign o_cout      = r_cout;
    assign o_ovf       = r_ovf;

    // state register
    always_ff @(posedge i_clk) begin
        if (!i_rst_b) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // next-state: accept, run WIDTH bits, hold until consumed
    always_comb begin
        w_next = r_state;
        if (r_state == IDLE && i_in_valid)  w_next = RUN;
        if (r_state == RUN && w_last)       w_next = HOLD;
        if (r_state == HOLD && i_out_ready) w_next = IDLE;
    end

    // datapath: operand latch on accept, one bit per cycle in RUN
    always_ff @(posedge i_clk) begin
        if (!i_rst_b) begin
            r_a    <= '0;
            r_b    <= '0;
            r_sum  <= '0;
            r_cnt  <= '0;
            r_c    <= 1'b0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_accept) begin
            r_a   <= i_a;
            r_b   <= i_sub ? ~i_b : i_b;
            r_c   <= i_sub | i_cin;
            r_cnt <= '0;
        end else if (r_state == RUN) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_sum <= {w_s, r_sum[WIDTH-1:1]};
            r_c   <= w_co;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
                // old carry flop is the carry into the MSB
                r_cout <= w_co;
                r_ovf  <= r_c ^ w_co;
            end
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed self-checking bench for the bit-serial adder/subtractor
module tb_serial_add_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_b = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         busy;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int errors = 0;
    int checks = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .i_clk(clk),
        .i_rst_b(rst_b),
        .i_in_valid(in_valid),
        .o_in_ready(in_ready),
        .i_a(a),
        .i_b(b),
        .i_cin(cin),
        .i_sub(sub),
        .o_busy(busy),
        .o_out_valid(out_valid),
        .i_out_ready(out_ready),
        .o_sum(sum),
        .o_cout(cout),
        .o_ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            $error("%s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tci, input logic ts, input logic [W-1:0] es,
                          input logic ec, input logic eo, input int hold);
        int lat;
        int busy_n;
        a = ta;
        b = tb;
        cin = tci;
        sub = ts;
        in_valid = 1'b1;
        chk({tag, ".in_ready_pre"}, 32'(in_ready), 32'd1);
        tick;
        a = ~ta;
        b = 8'($urandom);
        cin = ~tci;
        sub = ~ts;
        lat = 0;
        busy_n = 0;
        while (!out_valid && lat < 20) begin
            busy_n += int'(busy);
            if (lat == 3) a = 8'($urandom);
            tick;
            lat++;
        end
        in_valid = 1'b0;
        chk({tag, ".latency"}, 32'(lat), 32'(W));
        chk({tag, ".busy_cycles"}, 32'(busy_n), 32'(W));
        chk({tag, ".sum"}, 32'(sum), 32'(es));
        chk({tag, ".cout"}, 32'(cout), 32'(ec));
        chk({tag, ".ovf"}, 32'(ovf), 32'(eo));
        for (int i = 0; i < hold; i++) begin
            tick;
            chk({tag, ".hold_sum"}, 32'({out_valid, in_ready, busy, cout, ovf, sum}),
                32'({1'b1, 1'b0, 1'b0, ec, eo, es}));
        end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        chk({tag, ".idle_after"}, 32'({in_ready, busy, out_valid}), 32'b100);
    endtask

    initial begin
        tick;
        tick;
        chk("reset.flags", 32'({in_ready, busy, out_valid}), 32'b100);
        chk("reset.res", 32'({cout, ovf, sum}), 32'd0);
        rst_b = 1'b1;
        tick;
        chk("idle.flags", 32'({in_ready, busy, out_valid}), 32'b100);

        run_op("add_35_4a", 8'h35, 8'h4A, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b0, 0);
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0);
        run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 0);
        run_op("add_0f_cin", 8'h0F, 8'h00, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0, 0);
        run_op("sub_05_05", 8'h05, 8'h05, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 0);
        run_op("sub_10_20", 8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0, 0);
        run_op("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 0);
        run_op("bp_12_34", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, 5);

        a = 8'hAA;
        b = 8'h55;
        cin = 1'b0;
        sub = 1'b0;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        tick;
        chk("rst_mid.busy_before", 32'(busy), 32'd1);
        rst_b = 1'b0;
        tick;
        rst_b = 1'b1;
        chk("rst_mid.flags", 32'({in_ready, busy, out_valid}), 32'b100);
        chk("rst_mid.res", 32'({cout, ovf, sum}), 32'd0);
        tick;
        chk("rst_mid.no_result", 32'({in_ready, out_valid}), 32'b10);
        run_op("after_rst_01_01", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
